// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the single-port RAM and mem_arbiter.
// master: requesters plus RAM side; slave: the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_gnt_o;
  logic              mem_rvalid_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i;
  logic              if_stallreq_o;
  logic              mem_stallreq_o;

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, mem_gnt_o, mem_rvalid_o, mem_rdata_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, if_stallreq_o, mem_stallreq_o
  );

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, mem_gnt_o, mem_rvalid_o, mem_rdata_o,
           ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, if_stallreq_o, mem_stallreq_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one single-cycle RAM, MEM priority over IF.
// Define ARB_STARVE_GUARD_EN to let a starved fetch port win after STARVE_LIMIT denials.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2
  } rd_state_t;

  rd_state_t state_r;
  rd_state_t state_next_s;
  logic      if_gnt_s;
  logic      mem_gnt_s;
  logic      guard_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_r;

  assign guard_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

  // Starvation counter: counts IF denials, saturates, clears on any IF grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (if_gnt_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.if_req_i && !guard_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign guard_s = 1'b0;
`endif

  // Grant selection; everything is forced quiet while reset is held.
  always_comb begin
    if_gnt_s  = 1'b0;
    mem_gnt_s = 1'b0;
    if (!rst_i) begin
      if_gnt_s  = 1'b0;
      mem_gnt_s = 1'b0;
    end else if (bus.if_req_i && bus.mem_req_i) begin
      if_gnt_s  = guard_s;
      mem_gnt_s = !guard_s;
    end else begin
      if_gnt_s  = bus.if_req_i;
      mem_gnt_s = bus.mem_req_i;
    end
  end

  // RAM access drive and stall requests.
  always_comb begin
    bus.ram_ce_o       = 1'b0;
    bus.ram_we_o       = 1'b0;
    bus.ram_addr_o     = {ADDR_W{1'b0}};
    bus.ram_data_o     = {DATA_W{1'b0}};
    bus.if_gnt_o       = if_gnt_s;
    bus.mem_gnt_o      = mem_gnt_s;
    bus.if_stallreq_o  = rst_i && bus.if_req_i && !if_gnt_s;
    bus.mem_stallreq_o = rst_i && bus.mem_req_i && !mem_gnt_s;
    if (mem_gnt_s) begin
      bus.ram_ce_o   = 1'b1;
      bus.ram_we_o   = bus.mem_we_i;
      bus.ram_addr_o = bus.mem_addr_i;
      bus.ram_data_o = bus.mem_wdata_i;
    end else if (if_gnt_s) begin
      bus.ram_ce_o   = 1'b1;
      bus.ram_addr_o = bus.if_addr_i;
    end else begin
      bus.ram_ce_o   = 1'b0;
    end
  end

  // Pending-read state register (pending flag and owner in one encoding).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next pending read, independent of the previous one so reads pipeline back to back.
  always_comb begin
    state_next_s = ST_IDLE;
    if (if_gnt_s) begin
      state_next_s = ST_IF_RD;
    end else if (mem_gnt_s && !bus.mem_we_i) begin
      state_next_s = ST_MEM_RD;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // Read-data return to the owning port only.
  always_comb begin
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = {DATA_W{1'b0}};
    bus.mem_rvalid_o = 1'b0;
    bus.mem_rdata_o  = {DATA_W{1'b0}};
    case (state_r)
      ST_IF_RD: begin
        bus.if_rvalid_o = 1'b1;
        bus.if_rdata_o  = bus.ram_data_i;
      end
      ST_MEM_RD: begin
        bus.mem_rvalid_o = 1'b1;
        bus.mem_rdata_o  = bus.ram_data_i;
      end
      default: begin
        bus.if_rvalid_o  = 1'b0;
        bus.mem_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; builds with or without ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        mv;
    logic [31:0] md;
  } rv_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  rv_t  exp_q[$];

  logic [31:0] ram_mem [0:255];
  bit   [255:0] ram_written;
  logic [31:0] ref_mem [0:255];
  bit   [255:0] ref_written;

  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Single-port RAM model, read data valid the cycle after the access
  always @(posedge clk_i) begin
    if (bus.ram_ce_o && bus.ram_we_o) begin
      ram_mem[bus.ram_addr_o[9:2]]     <= bus.ram_data_o;
      ram_written[bus.ram_addr_o[9:2]] <= 1'b1;
    end
    if (bus.ram_ce_o && !bus.ram_we_o)
      bus.ram_data_i <= ram_written[bus.ram_addr_o[9:2]] ? ram_mem[bus.ram_addr_o[9:2]]
                                                         : pat(bus.ram_addr_o);
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_written[a[9:2]] ? ref_mem[a[9:2]] : pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    {31'd0, bus.if_gnt_o},       32'd0);
    chk({tag, ".mem_gnt"},   {31'd0, bus.mem_gnt_o},      32'd0);
    chk({tag, ".if_rv"},     {31'd0, bus.if_rvalid_o},    32'd0);
    chk({tag, ".mem_rv"},    {31'd0, bus.mem_rvalid_o},   32'd0);
    chk({tag, ".if_rd"},     bus.if_rdata_o,              32'd0);
    chk({tag, ".mem_rd"},    bus.mem_rdata_o,             32'd0);
    chk({tag, ".ram_ce"},    {31'd0, bus.ram_ce_o},       32'd0);
    chk({tag, ".ram_we"},    {31'd0, bus.ram_we_o},       32'd0);
    chk({tag, ".ram_addr"},  bus.ram_addr_o,              32'd0);
    chk({tag, ".ram_data"},  bus.ram_data_o,              32'd0);
    chk({tag, ".if_stall"},  {31'd0, bus.if_stallreq_o},  32'd0);
    chk({tag, ".mem_stall"}, {31'd0, bus.mem_stallreq_o}, 32'd0);
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic mreq,
                       input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata);
    bus.if_req_i    = ireq;
    bus.if_addr_i   = iaddr;
    bus.mem_req_i   = mreq;
    bus.mem_we_i    = mwe;
    bus.mem_addr_i  = maddr;
    bus.mem_wdata_i = mwdata;
  endtask

  // One clock cycle: drive, check combinational outputs and due rvalids, queue next rvalids
  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic mreq,
                      input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata,
                      input logic exp_ig, input logic exp_mg, input string tag);
    rv_t cur;
    rv_t nxt;
    drive(ireq, iaddr, mreq, mwe, maddr, mwdata);
    @(negedge clk_i);
    chk({tag, ".if_gnt"},    {31'd0, bus.if_gnt_o},       {31'd0, exp_ig});
    chk({tag, ".mem_gnt"},   {31'd0, bus.mem_gnt_o},      {31'd0, exp_mg});
    chk({tag, ".if_stall"},  {31'd0, bus.if_stallreq_o},  {31'd0, ireq & ~exp_ig});
    chk({tag, ".mem_stall"}, {31'd0, bus.mem_stallreq_o}, {31'd0, mreq & ~exp_mg});
    chk({tag, ".ram_ce"},    {31'd0, bus.ram_ce_o},       {31'd0, exp_ig | exp_mg});
    chk({tag, ".ram_we"},    {31'd0, bus.ram_we_o},       {31'd0, exp_mg & mwe});
    chk({tag, ".ram_addr"},  bus.ram_addr_o, exp_mg ? maddr : (exp_ig ? iaddr : 32'd0));
    chk({tag, ".ram_data"},  bus.ram_data_o, exp_mg ? mwdata : 32'd0);
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '{1'b0, 32'd0, 1'b0, 32'd0};
    chk({tag, ".if_rv"},  {31'd0, bus.if_rvalid_o},  {31'd0, cur.iv});
    chk({tag, ".if_rd"},  bus.if_rdata_o,            cur.id);
    chk({tag, ".mem_rv"}, {31'd0, bus.mem_rvalid_o}, {31'd0, cur.mv});
    chk({tag, ".mem_rd"}, bus.mem_rdata_o,           cur.md);
    nxt = '{1'b0, 32'd0, 1'b0, 32'd0};
    if (exp_ig) begin
      nxt.iv = 1'b1;
      nxt.id = ref_read(iaddr);
    end else if (exp_mg && mwe) begin
      ref_mem[maddr[9:2]]     = mwdata;
      ref_written[maddr[9:2]] = 1'b1;
    end else if (exp_mg) begin
      nxt.mv = 1'b1;
      nxt.md = ref_read(maddr);
    end
    exp_q.push_back(nxt);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // Requests held high during reset: outputs must still be quiet
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 32'h5555_AAAA);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "if_alone");
    idle("if_alone_rv");

    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b1, "mem_wr");
    idle("mem_wr_rv");
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b0, 1'b1, "mem_rdback");
    idle("mem_rdback_rv");

    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b1, "both_c0");
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "both_c1");
    idle("both_c2");

    for (int c = 0; c < 5; c++)
      step(1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0030 + 32'(c * 4), 32'd0,
           GUARD && (c == 4), !(GUARD && (c == 4)), $sformatf("starve%0d", c));
    idle("starve_rv");

    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "alt_if8");
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_000C, 32'd0, 1'b0, 1'b1, "alt_memC");
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "alt_if10");
    idle("alt_rv");

    step(1'b1, 32'h0000_0050, 1'b1, 1'b0, 32'h0000_0060, 32'd0, 1'b0, 1'b1, "cnt_one");
`ifdef ARB_STARVE_GUARD_EN
    chk("cnt_one.cnt", 32'(dut.starve_cnt_r), 32'd1);
`endif
    idle("cnt_one_rv");

    // Reset the cycle after an IF read grant: the pending read must vanish
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_rd");
    rst_i = 1'b0;
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    chk_all_zero("rst_mid");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
    chk("rst_mid.cnt", 32'(dut.starve_cnt_r), 32'd0);
`endif
    idle("rst_after0");
    idle("rst_after1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive IF denials before IF is forced to win.
REQ-002 Ports, one per line (name, direction, width, meaning). One clock clk_i; reset rst_i is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_i  in  1  async active-low reset.
- if_req_i  in  1  instruction-fetch read request.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DATA_W  fetch data.
- mem_req_i  in  1  data-port request.
- mem_we_i  in  1  1=write, 0=read.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  write data.
- mem_gnt_o  out  1  data request accepted this cycle.
- mem_rvalid_o  out  1  read data valid.
- mem_rdata_o  out  DATA_W  read data.
- ram_ce_o  out  1  RAM access enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_data_o  out  DATA_W  RAM write data.
- ram_data_i  in  DATA_W  RAM read data, valid one cycle after the read access.
- if_stallreq_o  out  1  fetch stall request to the pipeline controller.
- mem_stallreq_o  out  1  data-port stall request to the pipeline controller.

Function
REQ-003 At most one requester SHALL be granted per cycle; the grant is combinational from the current requests and registered state.
REQ-004 Default priority SHALL be MEM over IF; only a lone requester SHALL always be granted.
REQ-005 The granted requester's address, write enable and write data SHALL drive ram_* in the same cycle, with ram_ce_o=1. IF accesses SHALL always drive ram_we_o=0.
REQ-006 With no grant, ram_ce_o=0, ram_we_o=0 and ram_addr_o/ram_data_o=0.
REQ-007 A granted read SHALL set a pending-read register and record the owner (IF or MEM).
REQ-008 In the following cycle, the owner's rvalid SHALL be 1 and its rdata SHALL equal ram_data_i; the other port's rvalid SHALL be 0 and its rdata 0.
REQ-009 A granted write SHALL produce no rvalid.
REQ-010 Back-to-back grants SHALL be supported with no bubble; the pending read from cycle N and a new grant in cycle N+1 SHALL coexist.
REQ-011 if_stallreq_o SHALL equal if_req_i & ~if_gnt_o, and mem_stallreq_o SHALL equal mem_req_i & ~mem_gnt_o.
REQ-012 A starvation counter SHALL increment each cycle IF is requesting but not granted, saturating at STARVE_LIMIT, and SHALL clear on any IF grant.
REQ-013 Simultaneous requests with no guard active SHALL grant MEM, assert if_stallreq_o and increment the counter.
REQ-014 A request dropped while stalled SHALL leave no residual state except the counter value.

Reset
REQ-015 While rst_i=0, all outputs SHALL be 0, including both grants and both rvalids.
REQ-016 While rst_i=0, the pending-read register, owner register and starvation counter SHALL be cleared.
REQ-017 Reset asserted mid-read SHALL drop the read; no rvalid SHALL appear after reset release.

Configuration
REQ-018 Macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-019 When ARB_STARVE_GUARD_EN is defined, a contended cycle with counter==STARVE_LIMIT SHALL grant IF instead of MEM, then the counter SHALL clear.
REQ-020 When ARB_STARVE_GUARD_EN is undefined, strict MEM priority SHALL apply; the counter SHALL be absent and have no effect on grants.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- IF alone reads 0x100 (RAM returns 0xDEADBEEF): if_gnt_o=1 in cycle 0; if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 1; mem_rvalid_o=0.
- MEM write 0x200 <- 0x12345678: ram_we_o=1, ram_addr_o=0x200, ram_data_o=0x12345678 in the same cycle; no rvalid in the next cycle.
- Both request (MEM read 0x40, IF 0x0): mem_gnt_o=1 and if_stallreq_o=1 in cycle 0; IF granted in cycle 1; mem_rvalid_o=1 in cycle 1; if_rvalid_o=1 in cycle 2.
- Guard enabled with MEM requesting continuously and IF requesting: IF denied in cycles 0-3 and granted in cycle 4; guard disabled: IF never granted while MEM requests.
- Reset pulled low the cycle after an IF read grant: if_rvalid_o stays 0 through reset and after release; counter reads 0.
- Alternating reads IF 0x8, MEM 0xC, IF 0x10 with no contention: three grants in consecutive cycles; rvalids follow one cycle later, each to the correct owner.
